// File: rtl/speck_pkg.sv
// speck_pkg: shared definitions for the parametrised SPECK core.
//   state_t       FSM state encoding, also driven out on state_response
//   speck_cfg_t   parameter set of one standard SPECK variant
//   ror / rol     rotations on a word of run-time width w (w <= MAX_W)
// Optional feature macro: SPECK_DEC_EN (used by the core and round files).
package speck_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        KEYEXP = 4'd1,
        ENC    = 4'd2,
        DEC    = 4'd3,
        DONE   = 4'd4
    } state_t;

    typedef struct packed {
        int word_w;
        int key_words;
        int rounds;
        int alpha;
        int beta;
    } speck_cfg_t;

    localparam speck_cfg_t SPECK_32_64   = '{16, 4, 22, 7, 2};
    localparam speck_cfg_t SPECK_64_128  = '{32, 4, 27, 8, 3};
    localparam speck_cfg_t SPECK_128_128 = '{64, 2, 32, 8, 3};
    localparam speck_cfg_t SPECK_128_256 = '{64, 4, 34, 8, 3};

    // Operand must already be zero above bit w-1; result is masked to w bits.
    function automatic logic [MAX_W-1:0] ror(input logic [MAX_W-1:0] v,
                                             input int unsigned w,
                                             input int unsigned s);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return ((v >> s) | (v << (w - s))) & mask;
    endfunction

    function automatic logic [MAX_W-1:0] rol(input logic [MAX_W-1:0] v,
                                             input int unsigned w,
                                             input int unsigned s);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return ((v << s) | (v >> (w - s))) & mask;
    endfunction

endpackage

// File: rtl/speck_core_param_if.sv
// speck_core_param_if: host <-> cipher core bundle.
//   master: host side (drives key_load, key_in, signal_start, mode, block_in)
//   slave : core side (drives block_out, finished, busy, key_ready, state_response)
// Handshake: signal_start/key_load are single-cycle requests that the core
// accepts only in IDLE (anything else is dropped, never queued); finished is a
// one-cycle pulse marking block_out valid, and block_out then holds until the
// next finished pulse.
interface speck_core_param_if #(
    parameter int WORD_W    = 64,
    parameter int KEY_WORDS = 2
);
    logic                          key_load;
    logic [KEY_WORDS*WORD_W-1:0]   key_in;
    logic                          signal_start;
    logic                          mode;
    logic [2*WORD_W-1:0]           block_in;
    logic [2*WORD_W-1:0]           block_out;
    logic                          finished;
    logic                          busy;
    logic                          key_ready;
    logic [3:0]                    state_response;

    modport master (
        output key_load, key_in, signal_start, mode, block_in,
        input  block_out, finished, busy, key_ready, state_response
    );

    modport slave (
        input  key_load, key_in, signal_start, mode, block_in,
        output block_out, finished, busy, key_ready, state_response
    );
endinterface

// File: rtl/speck_round.sv
// speck_round: one combinational SPECK round.
//   x, y     input words (x is the upper half of the block)
//   rk       round key
//   mode     0 = encrypt round, 1 = decrypt round
//   x_out, y_out  result words
// Optional feature macro: SPECK_DEC_EN compiles in the decrypt round; without
// it mode is ignored and the unit always encrypts.
module speck_round
    import speck_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] rk,
    input  logic              mode,
    output logic [WORD_W-1:0] x_out,
    output logic [WORD_W-1:0] y_out
);
    logic [WORD_W-1:0] enc_x, enc_y;

    always_comb begin
        enc_x = (WORD_W'(ror(MAX_W'(x), WORD_W, ALPHA)) + y) ^ rk;
        enc_y = WORD_W'(rol(MAX_W'(y), WORD_W, BETA)) ^ enc_x;
    end

`ifdef SPECK_DEC_EN
    logic [WORD_W-1:0] dec_x, dec_y, dec_diff;

    always_comb begin
        dec_y    = WORD_W'(ror(MAX_W'(x ^ y), WORD_W, BETA));
        dec_diff = (x ^ rk) - dec_y;
        dec_x    = WORD_W'(rol(MAX_W'(dec_diff), WORD_W, ALPHA));
    end

    assign x_out = mode ? dec_x : enc_x;
    assign y_out = mode ? dec_y : enc_y;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign x_out = enc_x;
    assign y_out = enc_y;
`endif
endmodule

// File: rtl/speck_core_param.sv
// speck_core_param: iterative SPECK core, one round per clock, with an
// internal key schedule filling a ROUNDS-deep round-key store.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         speck_core_param_if.slave (key_load/key_in, signal_start/mode/
//               block_in in; block_out/finished/busy/key_ready/state_response out)
// Optional feature macro: SPECK_DEC_EN adds the DEC state and decrypt path;
// without it mode is ignored and every start encrypts.
module speck_core_param
    import speck_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int KEY_WORDS = 2,
    parameter int ROUNDS    = 32,
    parameter int ALPHA     = 8,
    parameter int BETA      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    speck_core_param_if.slave        bus
);
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int LW = KEY_WORDS - 1;
    localparam logic [CW-1:0] LAST_KEY = CW'(ROUNDS - 2);
    localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       ctr_q;
    logic [WORD_W-1:0]   x_q, y_q, k_q;
    logic [WORD_W-1:0]   l_q [LW];
    logic [WORD_W-1:0]   rk_mem [ROUNDS];
    logic [2*WORD_W-1:0] block_out_q;
    logic                finished_q, key_ready_q;
    logic                dec_sel;

    logic [WORD_W-1:0]   rnd_x, rnd_y, rnd_k, rnd_x_out, rnd_y_out;
    logic                rnd_mode;
    logic                rk_we;
    logic [CW-1:0]       rk_wa;
    logic [WORD_W-1:0]   rk_wd;

`ifdef SPECK_DEC_EN
    assign dec_sel = bus.mode;
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
    assign dec_sel     = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.key_load)
                    state_d = KEYEXP;
                else if (bus.signal_start && key_ready_q)
                    state_d = dec_sel ? DEC : ENC;
            end
            KEYEXP:  if (ctr_q == LAST_KEY) state_d = IDLE;
            ENC:     if (ctr_q == LAST_RND) state_d = DONE;
`ifdef SPECK_DEC_EN
            DEC:     if (ctr_q == '0) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The key schedule step is an encrypt round with x=l[i], y=k[i], rk=i:
    // x_out becomes the new l word and y_out the next round key.
    always_comb begin
        rnd_x    = x_q;
        rnd_y    = y_q;
        rnd_k    = rk_mem[ctr_q];
        rnd_mode = (state_q == DEC);
        if (state_q == KEYEXP) begin
            rnd_x = l_q[0];
            rnd_y = k_q;
            rnd_k = WORD_W'(ctr_q);
        end
    end

    speck_round #(.WORD_W(WORD_W), .ALPHA(ALPHA), .BETA(BETA)) u_round (
        .x     (rnd_x),
        .y     (rnd_y),
        .rk    (rnd_k),
        .mode  (rnd_mode),
        .x_out (rnd_x_out),
        .y_out (rnd_y_out)
    );

    // Round-key store write port: rk[0]=k0 on load, rk[i+1] during expansion.
    always_comb begin
        rk_we = 1'b0;
        rk_wa = ctr_q + CW'(1);
        rk_wd = rnd_y_out;
        if (state_q == IDLE && bus.key_load) begin
            rk_we = 1'b1;
            rk_wa = '0;
            rk_wd = bus.key_in[WORD_W-1:0];
        end else if (state_q == KEYEXP) begin
            rk_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && rk_we)
            rk_mem[rk_wa] <= rk_wd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            for (int j = 0; j < LW; j++) l_q[j] <= '0;
            block_out_q <= '0;
            finished_q  <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            finished_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.key_load) begin
                        k_q <= bus.key_in[WORD_W-1:0];
                        for (int j = 0; j < LW; j++)
                            l_q[j] <= bus.key_in[(j+1)*WORD_W +: WORD_W];
                        key_ready_q <= 1'b0;
                        ctr_q       <= '0;
                    end else if (bus.signal_start && key_ready_q) begin
                        x_q   <= bus.block_in[2*WORD_W-1:WORD_W];
                        y_q   <= bus.block_in[WORD_W-1:0];
                        ctr_q <= dec_sel ? LAST_RND : '0;
                    end
                end
                KEYEXP: begin
                    k_q <= rnd_y_out;
                    // l words form a FIFO: consume l[i], append l[i+m-1]
                    for (int j = 0; j < LW - 1; j++) l_q[j] <= l_q[j+1];
                    l_q[LW-1] <= rnd_x_out;
                    if (ctr_q == LAST_KEY) begin
                        ctr_q       <= '0;
                        key_ready_q <= 1'b1;
                    end else begin
                        ctr_q <= ctr_q + CW'(1);
                    end
                end
                ENC: begin
                    x_q   <= rnd_x_out;
                    y_q   <= rnd_y_out;
                    ctr_q <= (ctr_q == LAST_RND) ? '0 : ctr_q + CW'(1);
                end
`ifdef SPECK_DEC_EN
                DEC: begin
                    x_q   <= rnd_x_out;
                    y_q   <= rnd_y_out;
                    ctr_q <= (ctr_q == '0) ? '0 : ctr_q - CW'(1);
                end
`endif
                DONE: begin
                    block_out_q <= {x_q, y_q};
                    finished_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.block_out      = block_out_q;
    assign bus.finished       = finished_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.key_ready      = key_ready_q;
    assign bus.state_response = state_q;
endmodule

// File: tb/tb_speck_core_param.sv
// tb_speck_core_param: directed and randomized checks of two core instances
// (Speck128/128 and Speck32/64) against known vectors and a reference model.
module tb_speck_core_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef SPECK_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [255:0] KEY_A = 256'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT_A  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] CT_A  = 128'ha65d985179783265_7860fedf5c570d18;
    localparam logic [255:0] KEY_B = 256'h1918_1110_0908_0100;
    localparam logic [127:0] PT_B  = 128'h6574_694c;
    localparam logic [127:0] CT_B  = 128'ha868_42f2;

    speck_core_param_if #(.WORD_W(64), .KEY_WORDS(2)) bus_a ();
    speck_core_param_if #(.WORD_W(16), .KEY_WORDS(4)) bus_b ();

    speck_core_param #(.WORD_W(64), .KEY_WORDS(2), .ROUNDS(32), .ALPHA(8), .BETA(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    speck_core_param #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(22), .ALPHA(7), .BETA(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0]  first_st;
    logic [63:0] m_rk [64];

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction
    function automatic logic [63:0] m_ror(input logic [63:0] v, input int s, input int w);
        return ((v >> s) | (v << (w - s))) & msk(w);
    endfunction
    function automatic logic [63:0] m_rol(input logic [63:0] v, input int s, input int w);
        return ((v << s) | (v >> (w - s))) & msk(w);
    endfunction

    task automatic model_expand(input logic [255:0] key, input int w, input int m,
                                input int t, input int a, input int b);
        logic [63:0] lq [$];
        logic [63:0] k, nl;
        k = 64'(key) & msk(w);
        for (int j = 1; j < m; j++) lq.push_back(64'(key >> (j * w)) & msk(w));
        m_rk[0] = k;
        for (int i = 0; i < t - 1; i++) begin
            nl = ((k + m_ror(lq.pop_front(), a, w)) & msk(w)) ^ 64'(i);
            lq.push_back(nl);
            k = m_rol(k, b, w) ^ nl;
            m_rk[i+1] = k;
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] blk, input int w,
                                               input int t, input int a, input int b);
        logic [63:0] x, y;
        x = 64'(blk >> w) & msk(w);
        y = 64'(blk) & msk(w);
        for (int r = 0; r < t; r++) begin
            x = ((m_ror(x, a, w) + y) & msk(w)) ^ m_rk[r];
            y = m_rol(y, b, w) ^ x;
        end
        return (128'(x) << w) | 128'(y);
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] blk, input int w,
                                               input int t, input int a, input int b);
        logic [63:0] x, y;
        x = 64'(blk >> w) & msk(w);
        y = 64'(blk) & msk(w);
        for (int r = t - 1; r >= 0; r--) begin
            y = m_ror(x ^ y, b, w);
            x = m_rol(((x ^ m_rk[r]) - y) & msk(w), a, w);
        end
        return (128'(x) << w) | 128'(y);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- DUT access (sel: 0 = dut_a, 1 = dut_b) ----------------
    task automatic set_in(input bit sel, input logic kl, input logic st, input logic md,
                          input logic [255:0] key, input logic [127:0] blk);
        if (sel) begin
            bus_b.key_load = kl; bus_b.signal_start = st; bus_b.mode = md;
            bus_b.key_in = key[63:0]; bus_b.block_in = blk[31:0];
        end else begin
            bus_a.key_load = kl; bus_a.signal_start = st; bus_a.mode = md;
            bus_a.key_in = key[127:0]; bus_a.block_in = blk;
        end
    endtask

    function automatic logic fin(input bit sel);
        return sel ? bus_b.finished : bus_a.finished;
    endfunction
    function automatic logic rdy(input bit sel);
        return sel ? bus_b.key_ready : bus_a.key_ready;
    endfunction
    function automatic logic bsy(input bit sel);
        return sel ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic [3:0] st(input bit sel);
        return sel ? bus_b.state_response : bus_a.state_response;
    endfunction
    function automatic logic [127:0] outb(input bit sel);
        return sel ? 128'(bus_b.block_out) : bus_a.block_out;
    endfunction

    // Called at a negedge; returns negedges until key_ready (bounded).
    task automatic load_key(input bit sel, input logic [255:0] key, output int cyc);
        set_in(sel, 1'b1, 1'b0, 1'b0, key, '0);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, key, '0);
        cyc = 1;
        while (!rdy(sel) && cyc < 300) begin @(negedge clk); cyc++; end
    endtask

    // Called at a negedge; returns at the negedge where finished is seen.
    task automatic run_op(input bit sel, input logic md, input logic [127:0] blk,
                          output logic [127:0] res, output int cyc);
        set_in(sel, 1'b0, 1'b1, md, '0, blk);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, '0, blk);
        cyc = 1;
        first_st = st(sel);
        while (!fin(sel) && cyc < 300) begin @(negedge clk); cyc++; end
        res = outb(sel);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res, exp, blk;
        logic [255:0] rkey;
        logic         md, seen;
        int           cyc;

        set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_block_out", outb(0), '0);
        check("rst_finished", 128'(fin(0)), 0);
        check("rst_busy", 128'(bsy(0)), 0);
        check("rst_key_ready", 128'(rdy(0)), 0);
        check("rst_state", 128'(st(0)), 0);
        check("rst_state_b", 128'(st(1)), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // start with no key loaded is ignored
        set_in(0, 1'b0, 1'b1, 1'b0, '0, PT_A);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, '0, PT_A);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (fin(0)) seen = 1'b1; end
        check("nokey_finished", 128'(seen), 0);
        check("nokey_state", 128'(st(0)), 0);

        // key load, with a start pulse dropped during KEYEXP
        set_in(0, 1'b1, 1'b0, 1'b0, KEY_A, PT_A);
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 1'b0, KEY_A, PT_A);
        check("kexp_state", 128'(st(0)), 1);
        check("kexp_key_ready", 128'(rdy(0)), 0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, KEY_A, PT_A);
        cyc = 2;
        while (!rdy(0) && cyc < 300) begin @(negedge clk); cyc++; end
        check("key_latency_a", 128'(cyc), 32);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (fin(0)) seen = 1'b1; end
        check("kexp_start_dropped", 128'(seen), 0);
        check("kexp_after_state", 128'(st(0)), 0);

        // known-answer encrypt
        model_expand(KEY_A, 64, 2, 32, 8, 3);
        run_op(0, 1'b0, PT_A, res, cyc);
        check("enc_kat_a", res, CT_A);
        check("enc_latency_a", 128'(cyc), 34);
        check("enc_state", 128'(first_st), 2);
        check("done_busy", 128'(bsy(0)), 0);
        @(negedge clk);
        check("finished_one_cycle", 128'(fin(0)), 0);
        check("block_out_hold", outb(0), CT_A);

        // known-answer decrypt (or re-encrypt when decrypt is not built)
        run_op(0, 1'b1, CT_A, res, cyc);
        exp = DEC_EN ? PT_A : model_enc(CT_A, 64, 32, 8, 3);
        check("dec_kat_a", res, exp);
        check("dec_latency_a", 128'(cyc), 34);
        check("dec_state", 128'(first_st), DEC_EN ? 128'd3 : 128'd2);

        // start/key_load pulsed during ENC are dropped
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 1'b0, KEY_A, PT_A);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) set_in(0, 1'b0, 1'b0, 1'b0, KEY_A, PT_A);
            if (cyc == 5) set_in(0, 1'b1, 1'b1, 1'b1, ~KEY_A, ~PT_A);
            if (cyc == 6) set_in(0, 1'b0, 1'b0, 1'b0, KEY_A, PT_A);
        end while (!fin(0) && cyc < 300);
        check("enc_ignore_result", outb(0), CT_A);
        check("enc_ignore_latency", 128'(cyc), 34);
        check("enc_ignore_key_ready", 128'(rdy(0)), 1);

        // random key, back-to-back random blocks
        rkey = 256'({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        load_key(0, rkey, cyc);
        check("rand_key_latency_a", 128'(cyc), 32);
        model_expand(rkey, 64, 2, 32, 8, 3);
        for (int i = 0; i < 6; i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            md  = 1'($urandom_range(0, 1));
            run_op(0, md, blk, res, cyc);
            exp = (DEC_EN && md) ? model_dec(blk, 64, 32, 8, 3) : model_enc(blk, 64, 32, 8, 3);
            check("rand_a_result", res, exp);
            check("rand_a_latency", 128'(cyc), 34);
        end

        // reset in the middle of an encryption
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 1'b0, '0, PT_A);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, '0, PT_A);
        repeat (10) @(negedge clk);
        check("mid_enc_state", 128'(st(0)), 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_block_out", outb(0), '0);
        check("midrst_finished", 128'(fin(0)), 0);
        check("midrst_busy", 128'(bsy(0)), 0);
        check("midrst_key_ready", 128'(rdy(0)), 0);
        check("midrst_state", 128'(st(0)), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (fin(0)) seen = 1'b1; end
        check("midrst_no_finished", 128'(seen), 0);
        load_key(0, KEY_A, cyc);
        run_op(0, 1'b0, PT_A, res, cyc);
        check("post_rst_kat_a", res, CT_A);
        check("post_rst_latency_a", 128'(cyc), 34);

        // Speck32/64 instance
        load_key(1, KEY_B, cyc);
        check("key_latency_b", 128'(cyc), 22);
        run_op(1, 1'b0, PT_B, res, cyc);
        check("enc_kat_b", res, CT_B);
        check("enc_latency_b", 128'(cyc), 24);
        model_expand(KEY_B, 16, 4, 22, 7, 2);
        run_op(1, 1'b1, CT_B, res, cyc);
        exp = DEC_EN ? PT_B : model_enc(CT_B, 16, 22, 7, 2);
        check("dec_kat_b", res, exp);
        rkey = 256'({$urandom, $urandom});
        @(negedge clk);
        load_key(1, rkey, cyc);
        model_expand(rkey, 16, 4, 22, 7, 2);
        for (int i = 0; i < 6; i++) begin
            blk = 128'($urandom);
            md  = 1'($urandom_range(0, 1));
            run_op(1, md, blk, res, cyc);
            exp = (DEC_EN && md) ? model_dec(blk, 16, 22, 7, 2) : model_enc(blk, 16, 22, 7, 2);
            check("rand_b_result", res, exp);
            check("rand_b_latency", 128'(cyc), 24);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
